// File: rtl/sw_hw_pio_bridge.sv
// sw_hw_pio_bridge: fabric-side endpoint of the Nios II PIO handshake.
// Software pushes words into an RX FIFO (drained by fabric over valid/ready)
// and pulls words from a TX FIFO (filled by fabric over valid/ready). The
// 2-bit command/status pair is a four-phase handshake: SW raises a command,
// HW acknowledges once, SW returns to IDLE, HW drops its status.
module sw_hw_pio_bridge #(
   parameter int DATA_W   = 8,
   parameter int RX_DEPTH = 16,
   parameter int TX_DEPTH = 16
) (
   input  logic                        clk_clk,
   input  logic                        reset_reset_n,
   input  logic [DATA_W-1:0]           pio_to_hw_port,
   input  logic [1:0]                  pio_to_hw_sig,
   output logic [DATA_W-1:0]           pio_to_sw_port,
   output logic [1:0]                  pio_to_sw_sig,
   output logic [DATA_W-1:0]           rx_data,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   input  logic [DATA_W-1:0]           tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic [$clog2(RX_DEPTH):0]   rx_level,
   output logic [$clog2(TX_DEPTH):0]   tx_level,
   output logic                        proto_err
);

   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam logic [RX_AW:0] RX_CAP = (RX_AW+1)'(RX_DEPTH);
   localparam logic [TX_AW:0] TX_CAP = (TX_AW+1)'(TX_DEPTH);

   // SW command codes
   localparam logic [1:0] CMD_IDLE  = 2'b00;
   localparam logic [1:0] CMD_WRITE = 2'b01;
   localparam logic [1:0] CMD_READ  = 2'b10;
   localparam logic [1:0] CMD_ABORT = 2'b11;

   // HW status codes
   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_WACK    = 2'b01;
   localparam logic [1:0] ST_RDATA   = 2'b10;
   localparam logic [1:0] ST_ABORTED = 2'b11;

   // FSM states
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WACK  = 2'd1;
   localparam logic [1:0] S_RACK  = 2'd2;
   localparam logic [1:0] S_ABORT = 2'd3;

   logic [1:0]        sig_q;
   logic [DATA_W-1:0] data_q;
   logic [1:0]        state;
   logic              ready_en;

   logic [DATA_W-1:0] rx_mem [RX_DEPTH];
   logic [DATA_W-1:0] tx_mem [TX_DEPTH];
   logic [RX_AW-1:0]  rx_wr;
   logic [RX_AW-1:0]  rx_rd;
   logic [TX_AW-1:0]  tx_wr;
   logic [TX_AW-1:0]  tx_rd;

   logic rx_full;
   logic tx_full;
   logic tx_empty;
   logic flush;
   logic rx_push;
   logic rx_pop;
   logic tx_push;
   logic tx_pop;

   // Derive FIFO status and all same-cycle push/pop/flush strobes from pre-edge state
   always_comb begin
      rx_full  = (rx_level == RX_CAP);
      tx_full  = (tx_level == TX_CAP);
      tx_empty = (tx_level == '0);
      rx_valid = (rx_level != '0);
      // Show-ahead head; forced to zero when empty so stale RAM never leaks out
      rx_data  = rx_valid ? rx_mem[rx_rd] : '0;
      // Flush starts on the edge that enters ABORT and is held while there
      flush    = (state == S_ABORT) || (sig_q == CMD_ABORT);
      // FSM-side transfers only happen from IDLE, so each handshake moves one word
      rx_push  = (state == S_IDLE) && (sig_q == CMD_WRITE) && !rx_full;
      tx_pop   = (state == S_IDLE) && (sig_q == CMD_READ) && !tx_empty;
      rx_pop   = rx_valid && rx_ready;
      tx_ready = ready_en && !tx_full && (state != S_ABORT);
      tx_push  = tx_valid && tx_ready;
   end

   // Register the SW command so the FSM never sees a half-changed PIO bus
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         sig_q <= CMD_IDLE;
      end else begin
         sig_q <= pio_to_hw_sig;
      end
   end

   // Word from SW travels alongside sig_q; no reset needed on the data path
   always_ff @(posedge clk_clk) begin
      data_q <= pio_to_hw_port;
   end

   // Hold tx_ready low through reset and release it on the first clean edge
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   // RX storage write port (pointer reset on flush makes stale entries unreachable)
   always_ff @(posedge clk_clk) begin
      if (rx_push) begin
         rx_mem[rx_wr] <= data_q;
      end
   end

   // TX storage write port
   always_ff @(posedge clk_clk) begin
      if (tx_push) begin
         tx_mem[tx_wr] <= tx_data;
      end
   end

   // RX pointers and occupancy; flush outranks any same-cycle push or pop
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         rx_wr    <= '0;
         rx_rd    <= '0;
         rx_level <= '0;
      end else if (flush) begin
         rx_wr    <= '0;
         rx_rd    <= '0;
         rx_level <= '0;
      end else begin
         if (rx_push) begin
            rx_wr <= rx_wr + 1'b1;
         end
         if (rx_pop) begin
            rx_rd <= rx_rd + 1'b1;
         end
         case ({rx_push, rx_pop})
            2'b10:   rx_level <= rx_level + 1'b1;
            2'b01:   rx_level <= rx_level - 1'b1;
            default: rx_level <= rx_level;
         endcase
      end
   end

   // TX pointers and occupancy; fabric push and FSM pop may coincide
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         tx_wr    <= '0;
         tx_rd    <= '0;
         tx_level <= '0;
      end else if (flush) begin
         tx_wr    <= '0;
         tx_rd    <= '0;
         tx_level <= '0;
      end else begin
         if (tx_push) begin
            tx_wr <= tx_wr + 1'b1;
         end
         if (tx_pop) begin
            tx_rd <= tx_rd + 1'b1;
         end
         case ({tx_push, tx_pop})
            2'b10:   tx_level <= tx_level + 1'b1;
            2'b01:   tx_level <= tx_level - 1'b1;
            default: tx_level <= tx_level;
         endcase
      end
   end

   // Handshake FSM: ABORT from any state wins, otherwise a four-phase handshake per state
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state          <= S_IDLE;
         pio_to_sw_sig  <= ST_IDLE;
         pio_to_sw_port <= '0;
         proto_err      <= 1'b0;
      end else if (sig_q == CMD_ABORT) begin
         state          <= S_ABORT;
         pio_to_sw_sig  <= ST_ABORTED;
         pio_to_sw_port <= '0;
         proto_err      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               case (sig_q)
                  CMD_WRITE: begin
                     if (!rx_full) begin
                        pio_to_sw_sig <= ST_WACK;
                        state         <= S_WACK;
                     end else begin
                        // RX full: stay silent so SW keeps polling
                        pio_to_sw_sig <= ST_IDLE;
                     end
                  end
                  CMD_READ: begin
                     if (!tx_empty) begin
                        pio_to_sw_port <= tx_mem[tx_rd];
                        pio_to_sw_sig  <= ST_RDATA;
                        state          <= S_RACK;
                     end else begin
                        pio_to_sw_sig <= ST_IDLE;
                     end
                  end
                  default: pio_to_sw_sig <= ST_IDLE;
               endcase
            end
            S_WACK: begin
               if (sig_q == CMD_IDLE) begin
                  pio_to_sw_sig <= ST_IDLE;
                  state         <= S_IDLE;
               end else if (sig_q == CMD_READ) begin
                  // SW changed command without releasing the write first
                  proto_err <= 1'b1;
               end
            end
            S_RACK: begin
               if (sig_q == CMD_IDLE) begin
                  // Port deliberately keeps the last word for late SW reads
                  pio_to_sw_sig <= ST_IDLE;
                  state         <= S_IDLE;
               end else if (sig_q == CMD_WRITE) begin
                  proto_err <= 1'b1;
               end
            end
            S_ABORT: begin
               if (sig_q == CMD_IDLE) begin
                  pio_to_sw_sig <= ST_IDLE;
                  state         <= S_IDLE;
               end
            end
            default: begin
               state         <= S_IDLE;
               pio_to_sw_sig <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sw_hw_pio_bridge.sv
// Bench for sw_hw_pio_bridge: directed handshake scenarios plus a random
// mix of SW writes/reads and fabric pushes/pops, checked against queue models.
module tb_sw_hw_pio_bridge;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] hw_port;
   logic [1:0] hw_sig;
   logic [7:0] sw_port;
   logic [1:0] sw_sig;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [4:0] rx_level;
   logic [4:0] tx_level;
   logic       proto_err;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] rxq[$];
   logic [7:0] txq[$];

   always #5 clk = ~clk;

   sw_hw_pio_bridge #(.DATA_W(8), .RX_DEPTH(16), .TX_DEPTH(16)) dut (
      .clk_clk        (clk),
      .reset_reset_n  (rst_n),
      .pio_to_hw_port (hw_port),
      .pio_to_hw_sig  (hw_sig),
      .pio_to_sw_port (sw_port),
      .pio_to_sw_sig  (sw_sig),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_level       (rx_level),
      .tx_level       (tx_level),
      .proto_err      (proto_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_levels();
      check_eq("rx_level", 32'(rx_level), 32'(rxq.size()));
      check_eq("tx_level", 32'(tx_level), 32'(txq.size()));
   endtask

   // One complete SW write handshake; a full RX must never acknowledge
   task automatic sw_write(input logic [7:0] w);
      hw_port = w;
      hw_sig  = 2'b01;
      if (rxq.size() < 16) begin
         tick(2);
         check_eq("wr_wack", 32'(sw_sig), 32'h1);
         rxq.push_back(w);
         check_levels();
      end else begin
         tick(4);
         check_eq("wr_full_stall", 32'(sw_sig), 32'h0);
         check_levels();
      end
      hw_sig = 2'b00;
      tick(2);
      check_eq("wr_release", 32'(sw_sig), 32'h0);
   endtask

   // One complete SW read handshake; an empty TX must never answer
   task automatic sw_read();
      logic [7:0] exp;
      hw_sig = 2'b10;
      if (txq.size() > 0) begin
         exp = txq.pop_front();
         tick(2);
         check_eq("rd_rdata", 32'(sw_sig), 32'h2);
         check_eq("rd_port", 32'(sw_port), 32'(exp));
         check_levels();
         hw_sig = 2'b00;
         tick(2);
         check_eq("rd_release", 32'(sw_sig), 32'h0);
         check_eq("rd_port_kept", 32'(sw_port), 32'(exp));
      end else begin
         tick(10);
         check_eq("rd_empty_stall", 32'(sw_sig), 32'h0);
         hw_sig = 2'b00;
         tick(2);
      end
   endtask

   task automatic fab_push(input logic [7:0] w);
      if (txq.size() < 16) begin
         check_eq("tx_ready", 32'(tx_ready), 32'h1);
         tx_data  = w;
         tx_valid = 1'b1;
         tick(1);
         tx_valid = 1'b0;
         txq.push_back(w);
      end else begin
         check_eq("tx_ready_full", 32'(tx_ready), 32'h0);
      end
      check_levels();
   endtask

   task automatic fab_pop();
      if (rxq.size() > 0) begin
         check_eq("rx_valid", 32'(rx_valid), 32'h1);
         check_eq("rx_data", 32'(rx_data), 32'(rxq[0]));
         rx_ready = 1'b1;
         tick(1);
         rx_ready = 1'b0;
         void'(rxq.pop_front());
      end else begin
         check_eq("rx_valid_empty", 32'(rx_valid), 32'h0);
         check_eq("rx_data_empty", 32'(rx_data), 32'h0);
      end
      check_levels();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_sig"}, 32'(sw_sig), 32'h0);
      check_eq({tag, "_port"}, 32'(sw_port), 32'h0);
      check_eq({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
      check_eq({tag, "_rx_data"}, 32'(rx_data), 32'h0);
      check_eq({tag, "_tx_ready"}, 32'(tx_ready), 32'h0);
      check_eq({tag, "_rx_level"}, 32'(rx_level), 32'h0);
      check_eq({tag, "_tx_level"}, 32'(tx_level), 32'h0);
      check_eq({tag, "_proto_err"}, 32'(proto_err), 32'h0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      rst_n    = 1'b0;
      hw_port  = '0;
      hw_sig   = 2'b00;
      rx_ready = 1'b0;
      tx_data  = '0;
      tx_valid = 1'b0;

      // Reset and idle
      tick(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick(1);
      check_eq("tx_ready_after_release", 32'(tx_ready), 32'h1);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check_eq("idle_sig", 32'(sw_sig), 32'h0);
      end

      // Single write with exact 2-cycle latency, then a long hold
      hw_port = 8'hA5;
      hw_sig  = 2'b01;
      tick(1);
      check_eq("wack_not_early", 32'(sw_sig), 32'h0);
      tick(1);
      check_eq("wack_latency", 32'(sw_sig), 32'h1);
      rxq.push_back(8'hA5);
      check_eq("a5_rx_valid", 32'(rx_valid), 32'h1);
      check_eq("a5_rx_data", 32'(rx_data), 32'hA5);
      check_levels();
      tick(50);
      check_eq("hold_one_push", 32'(rx_level), 32'h1);
      check_eq("hold_wack", 32'(sw_sig), 32'h1);
      hw_sig = 2'b00;
      tick(2);
      check_eq("a5_release", 32'(sw_sig), 32'h0);
      fab_pop();

      // Fill RX across pointer wrap, stall, then one fabric pop lets the write in
      for (int i = 0; i < 16; i++) sw_write(8'(i));
      check_eq("rx_full_level", 32'(rx_level), 32'd16);
      hw_port = 8'd16;
      hw_sig  = 2'b01;
      tick(6);
      check_eq("full_stall_sig", 32'(sw_sig), 32'h0);
      check_eq("full_stall_level", 32'(rx_level), 32'd16);
      check_eq("full_head", 32'(rx_data), 32'h0);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      void'(rxq.pop_front());
      ok = 1'b0;
      for (int i = 0; i < 6 && !ok; i++) begin
         if (sw_sig == 2'b01) ok = 1'b1;
         else tick(1);
      end
      check_eq("wack_after_pop", 32'(ok), 32'h1);
      rxq.push_back(8'd16);
      check_levels();
      hw_sig = 2'b00;
      tick(2);
      for (int i = 1; i <= 16; i++) begin
         check_eq("order", 32'(rx_data), 32'(i));
         fab_pop();
      end

      // Fabric to SW
      fab_push(8'h11);
      fab_push(8'h22);
      sw_read();
      sw_read();
      sw_read();

      // Random mix of all four operations
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 3))
            0: sw_write(8'($urandom));
            1: sw_read();
            2: fab_push(8'($urandom));
            default: fab_pop();
         endcase
      end

      // Protocol error in W_ACK, then abort
      while (rxq.size() > 0) fab_pop();
      while (txq.size() > 0) sw_read();
      hw_port = 8'h5A;
      hw_sig  = 2'b01;
      tick(2);
      check_eq("pe_wack", 32'(sw_sig), 32'h1);
      rxq.push_back(8'h5A);
      fab_push(8'h33);
      hw_sig = 2'b10;
      tick(2);
      check_eq("pe_set", 32'(proto_err), 32'h1);
      check_eq("pe_sig_hold", 32'(sw_sig), 32'h1);
      check_levels();
      tick(5);
      check_eq("pe_sticky", 32'(proto_err), 32'h1);
      hw_sig = 2'b11;
      tick(2);
      rxq.delete();
      txq.delete();
      check_eq("abort_sig", 32'(sw_sig), 32'h3);
      check_eq("abort_port", 32'(sw_port), 32'h0);
      check_eq("abort_pe_clear", 32'(proto_err), 32'h0);
      check_eq("abort_tx_ready", 32'(tx_ready), 32'h0);
      check_eq("abort_rx_valid", 32'(rx_valid), 32'h0);
      check_levels();
      hw_sig = 2'b00;
      tick(2);
      check_eq("abort_exit_sig", 32'(sw_sig), 32'h0);
      check_eq("abort_exit_tx_ready", 32'(tx_ready), 32'h1);

      // Protocol error in R_ACK: a write there must not push
      fab_push(8'h44);
      hw_sig = 2'b10;
      tick(2);
      check_eq("rack_port", 32'(sw_port), 32'h44);
      void'(txq.pop_front());
      hw_port = 8'h77;
      hw_sig  = 2'b01;
      tick(2);
      check_eq("rack_pe", 32'(proto_err), 32'h1);
      check_eq("rack_sig_hold", 32'(sw_sig), 32'h2);
      check_levels();
      hw_sig = 2'b00;
      tick(2);

      // Reset in the middle of R_ACK with three words still queued
      for (int i = 0; i < 4; i++) fab_push(8'($urandom_range(1, 255)));
      hw_sig = 2'b10;
      tick(2);
      check_eq("pre_rst_rdata", 32'(sw_sig), 32'h2);
      check_eq("pre_rst_port", 32'(sw_port), 32'(txq[0]));
      void'(txq.pop_front());
      check_levels();
      rst_n  = 1'b0;
      hw_sig = 2'b00;
      tick(1);
      rxq.delete();
      txq.delete();
      check_reset_outputs("midrst");
      rst_n = 1'b1;
      tick(1);
      check_eq("midrst_tx_ready", 32'(tx_ready), 32'h1);
      sw_write(8'hC3);
      fab_pop();
      fab_push(8'h3C);
      sw_read();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
